// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: control-word layout,
// funct3 encodings, FSM states and the alignment rule.
package mem_stage_pkg;

    localparam int CTRL_W      = 13;
    localparam int WB_CTRL_W   = 8;
    localparam int CTRL_MEM_WE = 12;
    localparam int CTRL_MEM_RE = 11;
    localparam int CTRL_F3_HI  = 10;
    localparam int CTRL_F3_LO  = 8;
    localparam int CTRL_RD_HI  = 7;
    localparam int CTRL_RD_LO  = 3;
    localparam int CTRL_REG_WE = 2;
    localparam int CTRL_SEL_HI = 1;
    localparam int CTRL_SEL_LO = 0;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       mem_we;
        logic       mem_re;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       reg_we;
        logic [1:0] res_sel;
    } ctrl_t;

    // Access size lives in funct3[1:0]; 11 is treated as a word and never traps.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = |lane;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load formatting: picks the addressed byte/halfword out of the read word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage with MEM/WB register: drives the data-memory req/ack
// port, stalls upstream while a request is outstanding, flags misalignment/timeouts.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int size    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [size-1:0]      FU_i,
    input  logic [size-1:0]      store_data_i,
    input  logic [size-1:0]      PCplus_i,
    input  logic [CTRL_W-1:0]    Control_Signal_i,
    output logic                 stall_o,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [size-1:0]      dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [size-1:0]      dmem_wdata,
    input  logic [size-1:0]      dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 valid_o,
    output logic [size-1:0]      FU_o,
    output logic [size-1:0]      MEM_result_o,
    output logic [size-1:0]      PCplus_o,
    output logic [WB_CTRL_W-1:0] Control_Signal_o,
    output logic                 exc_misalign_o,
    output logic                 exc_bus_o
);

    ctrl_t            ctrl;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             mem_op, is_store, is_load, misalign;
    logic             req, stall, done, mis_done, bus_err;
    logic [1:0]       lane;
    logic [3:0]       be;
    logic [size-1:0]  wdata, load_data;

    logic                 valid_q, valid_d;
    logic [size-1:0]      fu_q, fu_d;
    logic [size-1:0]      mem_q, mem_d;
    logic [size-1:0]      pc_q, pc_d;
    logic [WB_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic                 mis_q, mis_d;
    logic                 bus_q, bus_d;

    assign ctrl     = ctrl_t'(Control_Signal_i);
    assign lane     = FU_i[1:0];
    assign mem_op   = valid_i & (ctrl.mem_we | ctrl.mem_re);
    assign is_store = ctrl.mem_we;
    assign is_load  = ctrl.mem_re & ~ctrl.mem_we;
    assign misalign = is_misaligned(ctrl.funct3, lane);

    // Byte-lane steering shared by loads and stores.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data_i;
        case (ctrl.funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data_i;
            end
        endcase
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (lane),
        .funct3 (ctrl.funct3),
        .result (load_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        stall    = 1'b0;
        done     = 1'b0;
        mis_done = 1'b0;
        bus_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && misalign) begin
                    done     = 1'b1;
                    mis_done = 1'b1;
                end else if (mem_op) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (valid_i) begin
                    done = 1'b1;
                end
            end
            WAIT: begin
                req = 1'b1;
                // An ack on the last allowed cycle still completes normally.
                if (dmem_ack) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    done    = 1'b1;
                    bus_err = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // WB register loads every cycle; write-enable survives only on a clean completion.
    always_comb begin
        valid_d = done;
        fu_d    = FU_i;
        pc_d    = PCplus_i;
        mis_d   = mis_done;
        bus_d   = bus_err;
        ctrl_d  = {ctrl.rd, ctrl.reg_we & done & ~mis_done & ~bus_err, ctrl.res_sel};
        mem_d   = (done && req && dmem_ack && is_load) ? load_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fu_q    <= '0;
            mem_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fu_q    <= fu_d;
            mem_q   <= mem_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
        end
    end

    assign dmem_req         = reset & req;
    assign stall_o          = reset & stall;
    assign dmem_we          = dmem_req & is_store;
    assign dmem_addr        = {FU_i[size-1:2], 2'b00};
    assign dmem_be          = dmem_req ? be : 4'b0000;
    assign dmem_wdata       = wdata;

    assign valid_o          = valid_q;
    assign FU_o             = fu_q;
    assign MEM_result_o     = mem_q;
    assign PCplus_o         = pc_q;
    assign Control_Signal_o = ctrl_q;
    assign exc_misalign_o   = mis_q;
    assign exc_bus_o        = bus_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits directly upstream of the write-back stage.
- Takes the execute-stage result, store data, PC+4 and the control word.
- Performs loads/stores over a req/ack data-memory port with byte-lane steering, sign/zero extension, misalignment detection and an ack timeout.
- Presents registered FU/MEM/PC+4 values and the 8-bit write-back control word to write-back.

Parameters:
- size, 32, datapath width (fixed 32 for byte-lane logic).
- TIMEOUT, 16, max cycles waiting for dmem_ack before bus error (≥1).
- CNT_W, 5, timeout counter width (≥ clog2(TIMEOUT+1)).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_i  input  1  instruction present from execute.
- FU_i  input  size  ALU result; also the effective address for memory ops.
- store_data_i  input  size  rs2 value for stores.
- PCplus_i  input  size  PC+4.
- Control_Signal_i  input  13  [12] mem_we, [11] mem_re, [10:8] funct3, [7:3] rd, [2] reg WE, [1:0] result select.
- stall_o  output  1  hold upstream inputs stable while high.
- dmem_req  output  1  memory request.
- dmem_we  output  1  write enable.
- dmem_addr  output  size  word-aligned address ({FU_i[31:2],2'b00}).
- dmem_be  output  4  byte enables.
- dmem_wdata  output  size  lane-steered store data.
- dmem_rdata  input  size  read data, valid with ack.
- dmem_ack  input  1  request completed this cycle.
- valid_o  output  1  registered valid to write-back.
- FU_o  output  size  registered FU_i.
- MEM_result_o  output  size  registered formatted load data (0 for non-loads).
- PCplus_o  output  size  registered PCplus_i.
- Control_Signal_o  output  8  registered Control_Signal_i[7:0]; bit 2 forced 0 on any exception.
- exc_misalign_o  output  1  registered misaligned-access flag.
- exc_bus_o  output  1  registered timeout flag.

Behaviour:
- Reset (async, reset=0): all registered outputs 0, state IDLE, counter 0. dmem_req and stall_o are 0 while reset is asserted.
- mem op = valid_i & (mem_we | mem_re). Both set: treated as store.
- Misaligned:
  - funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]≠0.
  - No request is issued; completes in 1 cycle with exc_misalign_o=1, Control_Signal_o[2]=0, MEM_result_o=0.
- Non-memory valid instruction: registered through in 1 cycle; stall_o=0.
- FSM IDLE:
  - Aligned mem op: dmem_req=1 combinationally.
  - If dmem_ack in the same cycle: complete (register outputs at this edge), stay IDLE, stall_o=0.
  - Otherwise: stall_o=1, go to WAIT, counter←1.
- FSM WAIT:
  - dmem_req=1; dmem_* driven from the held inputs; stall_o=1 until completion; valid_o=0 while waiting.
  - On dmem_ack: complete, stall_o=0 that cycle, go to IDLE.
  - If counter=TIMEOUT and no ack: complete with exc_bus_o=1, WE cleared, MEM_result_o=0, go to IDLE.
  - Otherwise counter increments.
  - Ack arriving together with timeout: ack wins.
- Store lanes (lane=addr[1:0]):
  - SB: be=0001<<lane, wdata=byte replicated ×4.
  - SH: be=0011<<lane, wdata=halfword replicated ×2.
  - SW: be=1111.
- Load: be set as for stores. Data selected by lane, then extended:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
  - Unsupported funct3: treated as LW.
- Exception flags are 1-cycle pulses accompanying valid_o=1.
- valid_o=0 cycles still register Control_Signal_o with bit 2 forced 0.
- Reset mid-WAIT: state returns to IDLE immediately; any late ack is ignored.

Decomposition:
- Package mem_stage_pkg:
  - control-field bit indices;
  - funct3 localparams (LB/LH/LW/LBU/LHU, SB/SH/SW);
  - state enum {IDLE, WAIT}.
- Sub-module load_align: combinational lane selection plus sign/zero extension (inputs rdata, addr[1:0], funct3; output 32-bit result).

Test Plan:
- ADD, valid_i=1, FU_i=0x1234, Control[7:0]=0x2C → next cycle valid_o=1, FU_o=0x1234, Control_Signal_o=0x2C, stall_o never 1.
- LB at addr 0x103, zero-wait ack, rdata=0x80FF0000 → dmem_be=1000, dmem_addr=0x100, MEM_result_o=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x202, data 0xABCD, ack after 3 cycles → stall_o high 3 cycles, be=1100, wdata=0xABCDABCD, valid_o pulses once after ack.
- LW addr 0x101 → no dmem_req, exc_misalign_o=1, Control_Signal_o[2]=0, 1-cycle latency.
- LW, no ack, TIMEOUT=16 → stall_o high 16 cycles, then exc_bus_o=1, WE cleared, FSM back in IDLE.
- reset asserted in WAIT, ack arrives after reset release → outputs 0, no completion, dmem_req=0.
